// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier arbiter/sequencer.
//   state_t : sequencer states (IDLE, four partial-product steps, DONE)
//   SH0/SH4/SH8 : shifter select codes for the partial-product alignment
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL0 = 3'd1,
    MUL1 = 3'd2,
    MUL2 = 3'd3,
    MUL3 = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [1:0] SH0 = 2'b00;
  localparam logic [1:0] SH4 = 2'b01;
  localparam logic [1:0] SH8 = 2'b10;

endpackage

// File: rtl/rr_arb2.sv
// Two-input arbiter with a last-grant register.
//   clk, rst : clock, async active-low reset (last_grant resets to 1 so req[0] wins first)
//   en       : arbitration allowed this cycle (grant forced to 0 otherwise)
//   req[1:0] : request vector
//   grant    : one-hot grant, combinational; last_grant follows it on the edge
//   RR_EN    : 1 = round-robin on conflict, 0 = req[0] always wins on conflict
module rr_arb2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic last_grant;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req[0] && req[1]) begin
        // On conflict the round-robin mode hands the grant to the requester
        // that did not win last time.
        if (RR_EN && !last_grant) grant = 2'b10;
        else                      grant = 2'b01;
      end else begin
        grant = req;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          last_grant <= 1'b1;
    else if (grant[0]) last_grant <= 1'b0;
    else if (grant[1]) last_grant <= 1'b1;
  end

endmodule

// File: rtl/mult_arb_seq.sv
// Shares one 4x4 multiply / shift / accumulate datapath between two requesters.
// Arbitrates in IDLE, latches the winner's operands, steps through the four
// nibble partial products and returns a tagged 16-bit product on rsp_*.
//   clk, rst          : clock, async active-low reset
//   reqN_valid/a/b    : requester N operand pair; reqN_ready pulses on accept
//   op_a, op_b        : latched operands to the datapath
//   sel_a_hi/sel_b_hi : nibble selects, sel_shift : partial-product shift
//   acc_fb, acc_en    : accumulator feedback / load enable; acc_in : accumulator value
//   rsp_valid/data/id : result handshake, held until rsp_ready
//   busy              : high whenever not in IDLE
module mult_arb_seq
  import mult_pkg::*;
#(
  parameter int DW    = 8,
  parameter bit RR_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [DW-1:0]   req0_a,
  input  logic [DW-1:0]   req0_b,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [DW-1:0]   req1_a,
  input  logic [DW-1:0]   req1_b,
  output logic            req1_ready,
  output logic [DW-1:0]   op_a,
  output logic [DW-1:0]   op_b,
  output logic            sel_a_hi,
  output logic            sel_b_hi,
  output logic [1:0]      sel_shift,
  output logic            acc_fb,
  output logic            acc_en,
  input  logic [2*DW-1:0] acc_in,
  output logic            rsp_valid,
  output logic [2*DW-1:0] rsp_data,
  output logic            rsp_id,
  input  logic            rsp_ready,
  output logic            busy
);

  state_t     state, state_nx;
  logic [1:0] grant;
  logic       arb_en;

  // Gating with rst keeps the readies low while reset holds the FSM in IDLE.
  assign arb_en = (state == IDLE) && rst;

  rr_arb2 #(.RR_EN(RR_EN)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en),
    .req   ({req1_valid, req0_valid}),
    .grant (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant != 2'b00) state_nx = MUL0;
      MUL0:    state_nx = MUL1;
      MUL1:    state_nx = MUL2;
      MUL2:    state_nx = MUL3;
      MUL3:    state_nx = DONE;
      DONE:    if (rsp_valid && rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Step decode: al*bl, al*bh<<4, ah*bl<<4, ah*bh<<8. The first step clears
  // the accumulator by adding to zero instead of the old value.
  always_comb begin
    sel_a_hi  = 1'b0;
    sel_b_hi  = 1'b0;
    sel_shift = SH0;
    acc_fb    = 1'b0;
    acc_en    = 1'b0;
    case (state)
      MUL0: acc_en = 1'b1;
      MUL1: begin
        acc_en = 1'b1; acc_fb = 1'b1; sel_b_hi = 1'b1; sel_shift = SH4;
      end
      MUL2: begin
        acc_en = 1'b1; acc_fb = 1'b1; sel_a_hi = 1'b1; sel_shift = SH4;
      end
      MUL3: begin
        acc_en = 1'b1; acc_fb = 1'b1; sel_a_hi = 1'b1; sel_b_hi = 1'b1; sel_shift = SH8;
      end
      default: ;
    endcase
  end

  // The last partial product lands in the accumulator on the MUL3->DONE edge,
  // so the first DONE cycle captures it; rsp_valid doubles as the
  // "already captured" flag for the rest of DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a      <= '0;
      op_b      <= '0;
      rsp_id    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      if (grant[0]) begin
        op_a   <= req0_a;
        op_b   <= req0_b;
        rsp_id <= 1'b0;
      end else if (grant[1]) begin
        op_a   <= req1_a;
        op_b   <= req1_b;
        rsp_id <= 1'b1;
      end
      if (state == DONE) begin
        if (!rsp_valid) begin
          rsp_data  <= acc_in;
          rsp_valid <= 1'b1;
        end else if (rsp_ready) begin
          rsp_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_arb_seq.sv
// Bench for mult_arb_seq: two instances (index 0 round-robin, index 1 fixed
// priority), each closed around a behavioural 4x4 multiply/shift/accumulate
// datapath. A reference model predicts grants and products; a monitor
// compares responses from a scoreboard queue.
module tb_mult_arb_seq;

  typedef struct {
    logic        id;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        v0 [2], v1 [2], r0 [2], r1 [2];
  logic [7:0]  a0 [2], b0 [2], a1 [2], b1 [2];
  logic [7:0]  op_a [2], op_b [2];
  logic        sel_a_hi [2], sel_b_hi [2], acc_fb [2], acc_en [2];
  logic [1:0]  sel_shift [2];
  logic [15:0] acc [2];
  logic        rsp_valid [2], rsp_id [2], rsp_ready [2], busy [2];
  logic [15:0] rsp_data [2];

  logic [15:0] q0 [2][$];
  logic [15:0] q1 [2][$];
  exp_t        exq [2][$];
  exp_t        rq [2][$];
  logic        gq [2][$];

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc0_cnt [2] = '{0, 0};
  int   acc1_cnt [2] = '{0, 0};
  int   acc_cyc [2]  = '{0, 0};
  logic mbusy [2]    = '{1'b0, 1'b0};
  logic mlast [2]    = '{1'b1, 1'b1};
  logic seen [2]     = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  mult_arb_seq #(.DW(8), .RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(v0[0]), .req0_a(a0[0]), .req0_b(b0[0]), .req0_ready(r0[0]),
    .req1_valid(v1[0]), .req1_a(a1[0]), .req1_b(b1[0]), .req1_ready(r1[0]),
    .op_a(op_a[0]), .op_b(op_b[0]), .sel_a_hi(sel_a_hi[0]), .sel_b_hi(sel_b_hi[0]),
    .sel_shift(sel_shift[0]), .acc_fb(acc_fb[0]), .acc_en(acc_en[0]), .acc_in(acc[0]),
    .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]), .rsp_id(rsp_id[0]),
    .rsp_ready(rsp_ready[0]), .busy(busy[0])
  );

  mult_arb_seq #(.DW(8), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(v0[1]), .req0_a(a0[1]), .req0_b(b0[1]), .req0_ready(r0[1]),
    .req1_valid(v1[1]), .req1_a(a1[1]), .req1_b(b1[1]), .req1_ready(r1[1]),
    .op_a(op_a[1]), .op_b(op_b[1]), .sel_a_hi(sel_a_hi[1]), .sel_b_hi(sel_b_hi[1]),
    .sel_shift(sel_shift[1]), .acc_fb(acc_fb[1]), .acc_en(acc_en[1]), .acc_in(acc[1]),
    .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]), .rsp_id(rsp_id[1]),
    .rsp_ready(rsp_ready[1]), .busy(busy[1])
  );

  // Behavioural datapath: selected nibbles multiplied, shifted, accumulated.
  function automatic logic [15:0] pp(input logic [7:0] a, input logic [7:0] b,
                                     input logic ah, input logic bh, input logic [1:0] sh);
    logic [3:0]  na, nb;
    logic [15:0] p;
    na = ah ? a[7:4] : a[3:0];
    nb = bh ? b[7:4] : b[3:0];
    p  = 16'(na) * 16'(nb);
    case (sh)
      2'b01:   pp = p << 4;
      2'b10:   pp = p << 8;
      default: pp = p;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc[0] <= '0;
      acc[1] <= '0;
    end else begin
      for (int d = 0; d < 2; d++)
        if (acc_en[d])
          acc[d] <= (acc_fb[d] ? acc[d] : 16'h0) +
                    pp(op_a[d], op_b[d], sel_a_hi[d], sel_b_hi[d], sel_shift[d]);
    end
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", nm, d, act, exp, cyc);
    end
  endtask

  task automatic chk_rst(input int d);
    chk("rst_ops", d, {16'h0, op_a[d], op_b[d]}, 0);
    chk("rst_ctl", d, {sel_a_hi[d], sel_b_hi[d], sel_shift[d], acc_fb[d], acc_en[d],
                       r0[d], r1[d], busy[d]}, 0);
    chk("rst_rsp", d, {rsp_valid[d], rsp_id[d], rsp_data[d]}, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Requester drivers: present the head of each queue and hold it until the
  // monitor has seen that requester's ready.
  initial begin
    int dn0 [2];
    int dn1 [2];
    for (int d = 0; d < 2; d++) begin
      v0[d] = 0; v1[d] = 0; a0[d] = 0; b0[d] = 0; a1[d] = 0; b1[d] = 0;
      dn0[d] = 0; dn1[d] = 0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (!rst) begin
          v0[d] = 0; v1[d] = 0;
          dn0[d] = acc0_cnt[d]; dn1[d] = acc1_cnt[d];
        end else begin
          if (dn0[d] != acc0_cnt[d]) begin dn0[d] = acc0_cnt[d]; v0[d] = 0; end
          if (dn1[d] != acc1_cnt[d]) begin dn1[d] = acc1_cnt[d]; v1[d] = 0; end
          if (!v0[d] && q0[d].size() > 0) begin {a0[d], b0[d]} = q0[d].pop_front(); v0[d] = 1; end
          if (!v1[d] && q1[d].size() > 0) begin {a1[d], b1[d]} = q1[d].pop_front(); v1[d] = 1; end
        end
      end
    end
  end

  // Reference model + scoreboard monitor.
  initial forever begin
    logic w;
    exp_t e;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rst) begin
        exq[d].delete();
        mbusy[d] = 0; mlast[d] = 1; seen[d] = 0;
      end else begin
        chk("busy", d, busy[d], mbusy[d]);
        if (acc_en[d]) chk("shift_legal", d, sel_shift[d] == 2'b11, 0);
        if (mbusy[d] || !(v0[d] || v1[d])) begin
          chk("ready_idle", d, {r1[d], r0[d]}, 0);
        end else begin
          if (v0[d] && v1[d]) w = (d == 0) ? ~mlast[d] : 1'b0;
          else                w = v1[d];
          chk("grant", d, {r1[d], r0[d]}, w ? 2 : 1);
          e.id   = w;
          e.data = w ? 16'(a1[d]) * 16'(b1[d]) : 16'(a0[d]) * 16'(b0[d]);
          exq[d].push_back(e);
          gq[d].push_back(w);
          mlast[d] = w; mbusy[d] = 1; seen[d] = 0;
          acc_cyc[d] = cyc + 1;
        end
        if (r0[d]) acc0_cnt[d]++;
        if (r1[d]) acc1_cnt[d]++;
        if (rsp_valid[d]) begin
          if (exq[d].size() == 0) begin
            chk("rsp_unexpected", d, 1, 0);
          end else begin
            if (!seen[d]) begin
              seen[d] = 1;
              chk("latency", d, cyc - acc_cyc[d], 5);
            end
            chk("rsp_data", d, rsp_data[d], exq[d][0].data);
            chk("rsp_id", d, rsp_id[d], exq[d][0].id);
            if (rsp_ready[d]) begin
              rq[d].push_back(exq[d].pop_front());
              mbusy[d] = 0;
            end
          end
        end
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (n < 2000 && (q0[0].size() || q1[0].size() || q0[1].size() || q1[1].size() ||
           v0[0] || v1[0] || v0[1] || v1[1] || exq[0].size() || exq[1].size() ||
           mbusy[0] || mbusy[1])) begin
      step();
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL drain_timeout: traffic still pending after %0d cycles", n);
    end
    step();
  endtask

  initial begin
    int n;
    rsp_ready[0] = 1; rsp_ready[1] = 1;
    repeat (3) step();
    for (int d = 0; d < 2; d++) chk_rst(d);
    rst = 1;
    step();

    // Conflict from reset: req0 first, then req1.
    for (int d = 0; d < 2; d++) begin
      rq[d].delete();
      q0[d].push_back({8'd12, 8'd10});
      q1[d].push_back({8'd200, 8'd3});
    end
    drain();
    for (int d = 0; d < 2; d++) begin
      chk("conf_cnt", d, rq[d].size(), 2);
      chk("conf_first", d, {rq[d][0].id, rq[d][0].data}, {1'b0, 16'd120});
      chk("conf_second", d, {rq[d][1].id, rq[d][1].data}, {1'b1, 16'd600});
    end

    // Four back-to-back pairs: alternation (RR) vs req0 starvation of req1 (FP).
    for (int d = 0; d < 2; d++) begin
      gq[d].delete();
      for (int i = 0; i < 4; i++) begin
        q0[d].push_back(16'($urandom));
        q1[d].push_back(16'($urandom));
      end
    end
    drain();
    for (int d = 0; d < 2; d++) chk("pairs_cnt", d, gq[d].size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk("rr_alternate", 0, gq[0][i], i % 2);
      chk("fp_priority", 1, gq[1][i], (i >= 4) ? 1 : 0);
    end

    // Single request and nibble edge cases.
    for (int d = 0; d < 2; d++) begin
      rq[d].delete();
      q0[d].push_back(16'hFFFF);
      q0[d].push_back(16'h1001);
      q0[d].push_back(16'h00AB);
      q0[d].push_back(16'hF00F);
    end
    drain();
    for (int d = 0; d < 2; d++) begin
      chk("ff_ff", d, {rq[d][0].id, rq[d][0].data}, {1'b0, 16'hFE01});
      chk("10_01", d, rq[d][1].data, 16'h0010);
      chk("00_ab", d, rq[d][2].data, 16'h0000);
      chk("f0_0f", d, rq[d][3].data, 16'h0E10);
    end

    // Backpressure: result held 10 cycles with a competing request pending.
    for (int d = 0; d < 2; d++) begin
      gq[d].delete();
      rsp_ready[d] = 0;
      q0[d].push_back({8'd55, 8'd77});
      q1[d].push_back({8'd3, 8'd4});
    end
    n = 0;
    while (!rsp_valid[0] && n < 50) begin step(); n++; end
    chk("bp_valid_seen", 0, rsp_valid[0], 1);
    repeat (10) step();
    for (int d = 0; d < 2; d++) begin
      chk("bp_no_grant", d, gq[d].size(), 1);
      chk("bp_hold_valid", d, rsp_valid[d], 1);
      rsp_ready[d] = 1;
    end
    drain();

    // Random traffic with random consumer backpressure.
    for (int i = 0; i < 24; i++)
      for (int d = 0; d < 2; d++)
        if ($urandom_range(0, 1)) q0[d].push_back(16'($urandom));
        else                      q1[d].push_back(16'($urandom));
    for (int i = 0; i < 200; i++) begin
      step();
      rsp_ready[0] = 1'($urandom_range(0, 1));
      rsp_ready[1] = 1'($urandom_range(0, 1));
    end
    rsp_ready[0] = 1; rsp_ready[1] = 1;
    drain();

    // Reset in MUL2: everything back to zero at once, result lost.
    for (int d = 0; d < 2; d++) begin
      q0[d].push_back({8'hC3, 8'h5A});
      q1[d].push_back({8'h01, 8'h01});
    end
    n = 0;
    while (!(busy[0] && sel_a_hi[0] && !sel_b_hi[0]) && n < 50) begin step(); n++; end
    chk("reach_mul2", 0, {busy[0], sel_a_hi[0], sel_b_hi[0]}, 3'b110);
    rst = 0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk_rst(d);
      q0[d].delete();
      q1[d].delete();
    end
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_no_rsp", 0, rsp_valid[0], 0);
      chk("rst_no_rsp", 1, rsp_valid[1], 0);
    end
    rst = 1;
    step();
    for (int d = 0; d < 2; d++) begin
      rq[d].delete();
      q0[d].push_back({8'h9C, 8'h37});
    end
    drain();
    for (int d = 0; d < 2; d++) begin
      chk("post_rst_cnt", d, rq[d].size(), 1);
      chk("post_rst", d, {rq[d][0].id, rq[d][0].data}, {1'b0, 16'h2184});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
